// File: rtl/bits_pkg.sv
// Shared constants, width helpers and the request record used by the bit-stream unpacker.
package bits_pkg;

  localparam int DEF_IN_W    = 32;
  localparam int DEF_DEPTH   = 32;
  localparam int DEF_MAX_REQ = 15;

  function automatic int len_width(int max_req);
    return $clog2(max_req + 1);
  endfunction

  function automatic int cnt_width(int cap);
    return $clog2(cap + 1);
  endfunction

  localparam int DEF_LEN_W = len_width(DEF_MAX_REQ);
  localparam int DEF_CNT_W = cnt_width(DEF_IN_W * DEF_DEPTH);

  typedef struct packed {
    logic [DEF_LEN_W-1:0]   len;
    logic [DEF_MAX_REQ-1:0] data;
  } req_rec_t;

endpackage

// File: rtl/bits_window_extract.sv
// Combinational read window: returns len bits starting at bit rd_ptr of the circular buffer, zero above len.
module bits_window_extract
  import bits_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_REQ = DEF_MAX_REQ,
  localparam int LEN_W  = len_width(MAX_REQ),
  localparam int CAP    = DEPTH * IN_W,
  localparam int PTR_W  = $clog2(CAP)
) (
  input  logic [CAP-1:0]     buf_bits,
  input  logic [PTR_W-1:0]   rd_ptr,
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_REQ-1:0] data
);

  localparam int OFF_W = $clog2(IN_W);
  localparam int WP_W  = $clog2(DEPTH);

  logic [WP_W-1:0]    lo_idx;
  logic [WP_W-1:0]    hi_idx;
  logic [OFF_W-1:0]   off;
  logic [2*IN_W-1:0]  pair;
  logic [MAX_REQ-1:0] mask;

  // A run of at most MAX_REQ (<= IN_W) bits touches two adjacent words; hi_idx wraps DEPTH-1 -> 0.
  assign lo_idx = rd_ptr[PTR_W-1:OFF_W];
  assign off    = rd_ptr[OFF_W-1:0];
  assign hi_idx = lo_idx + WP_W'(1);
  assign pair   = {buf_bits[hi_idx*IN_W +: IN_W], buf_bits[lo_idx*IN_W +: IN_W]};
  assign mask   = ~({MAX_REQ{1'b1}} << len);
  assign data   = pair[off +: MAX_REQ] & mask;

endmodule

// File: rtl/bits_stream_unpacker.sv
// Bit-granular FIFO: IN_W-bit words in, 0..MAX_REQ-bit LSB-first runs out, flow control on both sides.
// Optional macro BITS_UNPACK_ERR_EN enables the sticky protocol-error flag (err tied 0 otherwise).
module bits_stream_unpacker
  import bits_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int MAX_REQ = DEF_MAX_REQ,
  localparam int LEN_W  = len_width(MAX_REQ),
  localparam int CAP    = DEPTH * IN_W,
  localparam int CNT_W  = cnt_width(CAP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pushin,
  input  logic [IN_W-1:0]    datain,
  output logic               in_ready,
  input  logic               reqin,
  input  logic [LEN_W-1:0]   reqlen,
  output logic               req_ready,
  output logic               pushout,
  output logic [LEN_W-1:0]   lenout,
  output logic [MAX_REQ-1:0] dataout,
  output logic [CNT_W-1:0]   count,
  output logic               err
);

  localparam int PTR_W = $clog2(CAP);
  localparam int WP_W  = $clog2(DEPTH);
  localparam bit LEN_CAN_OVER = MAX_REQ < (2**LEN_W - 1);

  // Handshakes: a word is accepted when pushin & in_ready, a request granted when reqin & req_ready;
  // both readies depend only on the registered count, never on the same-cycle partner transfer.
  logic [CAP-1:0]     bit_buf;
  logic [WP_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               len_bad;
  logic               accept;
  logic               grant;
  logic [MAX_REQ-1:0] win_data;
  logic               s1_valid;
  logic [LEN_W-1:0]   s1_len;
  logic [MAX_REQ-1:0] s1_data;
  logic               pushout_q;
  logic [LEN_W-1:0]   lenout_q;
  logic [MAX_REQ-1:0] dataout_q;

  assign len_bad   = LEN_CAN_OVER && (int'(reqlen) > MAX_REQ);
  assign in_ready  = count_q <= CNT_W'(CAP - IN_W);
  assign req_ready = !len_bad && (count_q >= CNT_W'(reqlen));
  assign accept    = pushin & in_ready;
  assign grant     = reqin & req_ready;

  bits_window_extract #(
    .IN_W    (IN_W),
    .DEPTH   (DEPTH),
    .MAX_REQ (MAX_REQ)
  ) u_extract (
    .buf_bits (bit_buf),
    .rd_ptr   (rd_ptr),
    .len      (reqlen),
    .data     (win_data)
  );

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      bit_buf[wr_ptr*IN_W +: IN_W] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + WP_W'(1);
      if (grant)  rd_ptr <= rd_ptr + PTR_W'(reqlen);
      count_q <= count_q + (accept ? CNT_W'(IN_W) : '0) - (grant ? CNT_W'(reqlen) : '0);
    end
  end

  // Window is captured at grant time, since freed words may be rewritten on the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_len    <= '0;
      s1_data   <= '0;
      pushout_q <= 1'b0;
      lenout_q  <= '0;
      dataout_q <= '0;
    end else begin
      s1_valid  <= grant;
      pushout_q <= s1_valid;
      if (grant) begin
        s1_len  <= reqlen;
        s1_data <= win_data;
      end
      if (s1_valid) begin
        lenout_q  <= s1_len;
        dataout_q <= s1_data;
      end
    end
  end

  assign pushout = pushout_q;
  assign lenout  = lenout_q;
  assign dataout = dataout_q;
  assign count   = count_q;

`ifdef BITS_UNPACK_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((pushin && !in_ready) || (reqin && !req_ready) || (reqin && len_bad)) begin
      err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bits_stream_unpacker.sv
// Self-checking bench for bits_stream_unpacker: bit-queue reference model plus directed literal checks.
module tb_bits_stream_unpacker;
  import bits_pkg::*;

  localparam int IN_W    = DEF_IN_W;
  localparam int DEPTH   = DEF_DEPTH;
  localparam int MAX_REQ = DEF_MAX_REQ;
  localparam int LEN_W   = DEF_LEN_W;
  localparam int CNT_W   = DEF_CNT_W;
  localparam int CAP     = IN_W * DEPTH;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               pushin;
  logic [IN_W-1:0]    datain;
  logic               in_ready;
  logic               reqin;
  logic [LEN_W-1:0]   reqlen;
  logic               req_ready;
  logic               pushout;
  logic [LEN_W-1:0]   lenout;
  logic [MAX_REQ-1:0] dataout;
  logic [CNT_W-1:0]   count;
  logic               err;

  always #5 clk = ~clk;

  bits_stream_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .pushin    (pushin),
    .datain    (datain),
    .in_ready  (in_ready),
    .reqin     (reqin),
    .reqlen    (reqlen),
    .req_ready (req_ready),
    .pushout   (pushout),
    .lenout    (lenout),
    .dataout   (dataout),
    .count     (count),
    .err       (err)
  );

  // ---------------- reference model / scoreboard ----------------
  int tests = 0;
  int fails = 0;

  bit       mq[$];                    // bits held, front = oldest
  req_rec_t exp_q[$];                 // granted runs awaiting output, in order
  bit       g1;                       // a grant is one stage from the output
  bit       ex_push;
  req_rec_t ex_out;
  bit       ex_err;
  bit       model_valid = 1'b0;

  function automatic bit m_in_ready();
    return (CAP - mq.size()) >= IN_W;
  endfunction

  function automatic bit m_req_ready(int len);
    return (len <= MAX_REQ) && (mq.size() >= len);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step();
    bit       rdy_in;
    bit       rdy_req;
    req_rec_t rec;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      g1      = 1'b0;
      ex_push = 1'b0;
      ex_out  = '0;
      ex_err  = 1'b0;
      model_valid = 1'b1;
      return;
    end
    rdy_in  = m_in_ready();
    rdy_req = m_req_ready(int'(reqlen));
    ex_push = g1;
    if (ex_push) ex_out = exp_q.pop_front();
    g1 = reqin && rdy_req;
    if (g1) begin
      rec = '0;
      rec.len = reqlen;
      for (int i = 0; i < int'(reqlen); i++) rec.data[i] = mq.pop_front();
      exp_q.push_back(rec);
    end
    if (pushin && rdy_in) begin
      for (int i = 0; i < IN_W; i++) mq.push_back(datain[i]);
    end
`ifdef BITS_UNPACK_ERR_EN
    if ((pushin && !rdy_in) || (reqin && !rdy_req)) ex_err = 1'b1;
`endif
  endtask

  // One clock: readies checked with inputs settled, model stepped at the edge,
  // registered outputs checked on the falling edge.
  task automatic tick();
    #1;
    if (model_valid && !rst) begin
      chk("in_ready", in_ready, m_in_ready());
      chk("req_ready", req_ready, m_req_ready(int'(reqlen)));
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("pushout", pushout, ex_push);
    chk("lenout", lenout, ex_out.len);
    chk("dataout", dataout, ex_out.data);
    chk("count", count, mq.size());
    chk("err", err, ex_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    rst = 1'b0; pushin = 1'b0; datain = '0; reqin = 1'b0; reqlen = '0;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic push_word(logic [IN_W-1:0] w);
    pushin = 1'b1; datain = w;
    tick();
    pushin = 1'b0;
  endtask

  task automatic req(int n);
    reqin = 1'b1; reqlen = LEN_W'(n);
    tick();
    reqin = 1'b0; reqlen = '0;
  endtask

  task automatic random_traffic(int cycles, int push_pct, int req_pct);
    for (int c = 0; c < cycles; c++) begin
      pushin = ($urandom_range(0, 99) < push_pct);
      datain = $urandom();
      reqin  = ($urandom_range(0, 99) < req_pct);
      reqlen = LEN_W'($urandom_range(0, MAX_REQ));
      tick();
    end
    set_idle();
  endtask

  logic [IN_W-1:0] w_last;
  bit              exp_err_lit;

  initial begin
`ifdef BITS_UNPACK_ERR_EN
    exp_err_lit = 1'b1;
`else
    exp_err_lit = 1'b0;
`endif
    set_idle();
    @(negedge clk);
    do_reset(2);

    // Basic extraction from one word.
    push_word(32'hDEADBEEF);
    chk("basic count after push", count, 32);
    req(4);
    req(4);
    chk("basic run0 pushout", pushout, 1);
    chk("basic run0 data", dataout, 15'h000F);
    req(8);
    chk("basic run1 data", dataout, 15'h000E);
    req(15);
    chk("basic run2 data", dataout, 15'h00BE);
    chk("basic run2 len", lenout, 8);
    req(1);
    chk("basic run3 data", dataout, 15'h5EAD);
    tick();
    chk("basic run4 data", dataout, 15'h0001);
    chk("basic count drained", count, 0);

    // Full buffer and refused push.
    do_reset(1);
    for (int i = 0; i < DEPTH; i++) begin
      w_last = $urandom();
      push_word(w_last);
    end
    chk("full count", count, CAP);
    chk("full in_ready", in_ready, 0);
    push_word($urandom());
    chk("full refused count", count, CAP);
    chk("full err", err, exp_err_lit);

    // Read window spanning the CAP -> 0 wrap.
    repeat (68) req(15);
    tick();
    tick();
    chk("wrap count before", count, 4);
    push_word(32'h00000005);
    req(12);
    tick();
    chk("wrap pushout", pushout, 1);
    chk("wrap data", dataout, {3'b000, 8'h05, w_last[31:28]});

    // Underflow refused, then granted once data arrives.
    do_reset(1);
    push_word($urandom());
    req(15);
    req(14);
    tick();
    tick();
    chk("under count", count, 3);
    reqin = 1'b1; reqlen = 5;
    #1;
    chk("under req_ready", req_ready, 0);
    tick();
    reqin = 1'b0; reqlen = '0;
    tick();
    tick();
    chk("under no pushout", pushout, 0);
    chk("under err", err, exp_err_lit);
    push_word($urandom());
    req(5);
    tick();
    chk("under late grant pushout", pushout, 1);
    chk("under late grant len", lenout, 5);

    // Simultaneous accept and grant, then a zero-length request.
    do_reset(1);
    push_word($urandom());
    pushin = 1'b1; datain = $urandom(); reqin = 1'b1; reqlen = 15;
    tick();
    set_idle();
    chk("simul count", count, 49);
    req(0);
    tick();
    chk("zero pushout", pushout, 1);
    chk("zero len", lenout, 0);
    chk("zero data", dataout, 0);

    // Randomized traffic across fill levels, with a mid-traffic reset.
    random_traffic(600, 70, 40);
    random_traffic(600, 30, 80);
    pushin = 1'b1; reqin = 1'b1; reqlen = 7; datain = $urandom();
    rst = 1'b1;
    repeat (3) tick();
    set_idle();
    chk("reset pushout", pushout, 0);
    chk("reset count", count, 0);
    chk("reset lenout", lenout, 0);
    chk("reset dataout", dataout, 0);
    chk("reset err", err, 0);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset req_ready len0", req_ready, 1);
    reqlen = 1;
    #1;
    chk("reset req_ready len1", req_ready, 0);
    reqlen = 0;
    random_traffic(1500, 55, 60);
    random_traffic(800, 90, 20);
    random_traffic(800, 20, 90);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
